// File: rtl/sddt_pkg.sv
// Shared definitions for the sddt command path: maintenance command words,
// status word layout, output-source tag and output-stage state encoding.
package sddt_pkg;

  localparam int unsigned CMD_W  = 128;
  localparam int unsigned PEND_W = 4;
  localparam int unsigned REFS_W = 16;

  // sddt_core encoding: bit 127 marks an internally generated command, [7:0] is the opcode.
  localparam logic [CMD_W-1:0] REF_CMD_WORD = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [CMD_W-1:0] ZQ_CMD_WORD  = 128'h8000_0000_0000_0000_0000_0000_0000_0002;

  // Status word layout.
  localparam int unsigned STAT_PEND_LSB = 0;
  localparam int unsigned STAT_OVF_BIT  = 4;
  localparam int unsigned STAT_URG_BIT  = 5;
  localparam int unsigned STAT_ZQ_BIT   = 6;
  localparam int unsigned STAT_TAG_BIT  = 7;
  localparam int unsigned STAT_REFS_LSB = 16;

  typedef enum logic {
    SrcHost  = 1'b0,
    SrcMaint = 1'b1
  } src_tag_e;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } out_state_e;

endpackage

// File: rtl/maint_timer.sv
// Refresh bookkeeping: tREFI interval counter, saturating postponed-refresh
// count with sticky overflow, ZQ-after-N-refreshes counter and issued-REF count.
module maint_timer
  import sddt_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 5200,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned ZQ_EVERY     = 128,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              maint_en,
  input  logic              take_ref,
  input  logic              take_zq,
  output logic [PEND_W-1:0] pending,
  output logic              urgent,
  output logic              zq_pend,
  output logic              overflow,
  output logic [REFS_W-1:0] ref_count
);

  localparam logic [CNT_W-1:0]  IvlLast  = CNT_W'(REF_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PendMax  = PEND_W'(MAX_PENDING);
  localparam bit                ZqEnable = (ZQ_EVERY != 0);
  // Only meaningful when ZqEnable is set.
  localparam logic [CNT_W-1:0]  ZqLast   = CNT_W'(ZQ_EVERY - 1);

  logic [CNT_W-1:0]  ivl_q, ivl_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  zq_cnt_q, zq_cnt_d;
  logic              zq_q, zq_d;
  logic              ovf_q, ovf_d;
  logic [REFS_W-1:0] refs_q, refs_d;
  logic              wrap;

  assign wrap = maint_en & (ivl_q == IvlLast);

  // Next-state for all counters; a REF taken in a wrap cycle cancels the new request.
  always_comb begin
    ivl_d    = ivl_q;
    pend_d   = pend_q;
    zq_cnt_d = zq_cnt_q;
    zq_d     = zq_q;
    ovf_d    = ovf_q;
    refs_d   = refs_q;
    if (take_ref) begin
      refs_d = refs_q + 1'b1;
    end
    if (!maint_en) begin
      ivl_d    = '0;
      pend_d   = '0;
      zq_cnt_d = '0;
      zq_d     = 1'b0;
    end else begin
      ivl_d = wrap ? '0 : ivl_q + 1'b1;
      if (wrap && (pend_q == PendMax)) begin
        ovf_d = 1'b1;
      end
      if (wrap && !take_ref && (pend_q != PendMax)) begin
        pend_d = pend_q + 1'b1;
      end else if (take_ref && !wrap && (pend_q != '0)) begin
        pend_d = pend_q - 1'b1;
      end
      if (take_zq) begin
        zq_d = 1'b0;
      end
      if (take_ref && ZqEnable) begin
        if (zq_cnt_q == ZqLast) begin
          zq_cnt_d = '0;
          zq_d     = 1'b1;
        end else begin
          zq_cnt_d = zq_cnt_q + 1'b1;
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ivl_q    <= '0;
      pend_q   <= '0;
      zq_cnt_q <= '0;
      zq_q     <= 1'b0;
      ovf_q    <= 1'b0;
      refs_q   <= '0;
    end else begin
      ivl_q    <= ivl_d;
      pend_q   <= pend_d;
      zq_cnt_q <= zq_cnt_d;
      zq_q     <= zq_d;
      ovf_q    <= ovf_d;
      refs_q   <= refs_d;
    end
  end

  assign pending   = pend_q;
  assign urgent    = (pend_q == PendMax);
  assign zq_pend   = zq_q;
  assign overflow  = ovf_q;
  assign ref_count = refs_q;

endmodule

// File: rtl/cmd_maint_scheduler.sv
// Merges host commands and generated REF/ZQCS maintenance commands onto the
// single sddt_core command stream through one output register stage.
module cmd_maint_scheduler
  import sddt_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 5200,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned ZQ_EVERY     = 128,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             maint_en,
  input  logic [CMD_W-1:0] S_AXIS_HOST_tdata,
  input  logic             S_AXIS_HOST_tvalid,
  output logic             S_AXIS_HOST_tready,
  output logic [CMD_W-1:0] M_AXIS_CMD_tdata,
  output logic             M_AXIS_CMD_tvalid,
  input  logic             M_AXIS_CMD_tready,
  output logic [31:0]      status
);

  out_state_e        state_q, state_d;
  logic [CMD_W-1:0]  data_q;
  src_tag_e          tag_q;
  logic              run_q;

  logic [PEND_W-1:0] pending;
  logic              urgent;
  logic              zq_pend;
  logic              overflow;
  logic [REFS_W-1:0] ref_count;

  logic load_ok, maint_force, maint_sel, host_load, load, take_ref, take_zq;

  maint_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .MAX_PENDING (MAX_PENDING),
    .ZQ_EVERY    (ZQ_EVERY),
    .CNT_W       (CNT_W)
  ) u_maint_timer (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .maint_en (maint_en),
    .take_ref (take_ref),
    .take_zq  (take_zq),
    .pending  (pending),
    .urgent   (urgent),
    .zq_pend  (zq_pend),
    .overflow (overflow),
    .ref_count(ref_count)
  );

  // run_q keeps host tready low through reset and the first cycle after it.
  assign load_ok     = run_q & ((state_q == StIdle) | M_AXIS_CMD_tready);
  // Maintenance that wins even over a valid host beat; host tready depends only on this.
  assign maint_force = zq_pend | urgent;
  assign maint_sel   = load_ok & (maint_force | ((pending != '0) & ~S_AXIS_HOST_tvalid));
  assign host_load   = S_AXIS_HOST_tvalid & S_AXIS_HOST_tready;
  assign load        = maint_sel | host_load;
  assign take_zq     = maint_sel & zq_pend;
  assign take_ref    = maint_sel & ~zq_pend;

  // Output-stage state register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Output-stage next state: stays full while loads keep replacing drained beats.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load) state_d = StHold;
      StHold: if (M_AXIS_CMD_tready && !load) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output payload; rewritten only on a load so a stalled beat stays stable.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      data_q <= '0;
      tag_q  <= SrcHost;
    end else if (load) begin
      if (maint_sel) begin
        data_q <= zq_pend ? ZQ_CMD_WORD : REF_CMD_WORD;
        tag_q  <= SrcMaint;
      end else begin
        data_q <= S_AXIS_HOST_tdata;
        tag_q  <= SrcHost;
      end
    end
  end

  // Stream outputs and status word.
  always_comb begin
    M_AXIS_CMD_tvalid  = (state_q == StHold);
    M_AXIS_CMD_tdata   = data_q;
    S_AXIS_HOST_tready = load_ok & ~maint_force;
    status                               = '0;
    status[STAT_PEND_LSB +: PEND_W]      = pending;
    status[STAT_OVF_BIT]                 = overflow;
    status[STAT_URG_BIT]                 = urgent;
    status[STAT_ZQ_BIT]                  = zq_pend;
    status[STAT_TAG_BIT]                 = (tag_q == SrcMaint);
    status[STAT_REFS_LSB +: REFS_W]      = ref_count;
  end

endmodule

// File: tb/tb_cmd_maint_scheduler.sv
// Randomised bench for cmd_maint_scheduler against a cycle-level behavioural model.
module tb_cmd_maint_scheduler;

  localparam int RI   = 10;
  localparam int MAXP = 8;
  localparam int ZQE  = 2;
  localparam logic [127:0] REF_W = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] ZQ_W  = 128'h8000_0000_0000_0000_0000_0000_0000_0002;

  logic         clk = 1'b0;
  logic         rstn, en, hv, tr;
  logic [127:0] hd;
  logic         hready, ovalid;
  logic [127:0] odata;
  logic [31:0]  status;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state.
  bit           mdl_run, mdl_valid, mdl_tag, mdl_zq, mdl_ovf, mdl_hacc;
  int           mdl_cnt, mdl_pend, mdl_zqc;
  logic [15:0]  mdl_issued;
  logic [127:0] mdl_data;

  cmd_maint_scheduler #(
    .REF_INTERVAL(RI),
    .MAX_PENDING (MAXP),
    .ZQ_EVERY    (ZQE),
    .CNT_W       (8)
  ) dut (
    .axi_aclk          (clk),
    .axi_aresetn       (rstn),
    .maint_en          (en),
    .S_AXIS_HOST_tdata (hd),
    .S_AXIS_HOST_tvalid(hv),
    .S_AXIS_HOST_tready(hready),
    .M_AXIS_CMD_tdata  (odata),
    .M_AXIS_CMD_tvalid (ovalid),
    .M_AXIS_CMD_tready (tr),
    .status            (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[3:0]   = 4'(mdl_pend);
    s[4]     = mdl_ovf;
    s[5]     = (mdl_pend == MAXP);
    s[6]     = mdl_zq;
    s[7]     = mdl_tag;
    s[31:16] = mdl_issued;
    return s;
  endfunction

  // Host may pass only when the stage can load and no forced maintenance is due.
  function automatic bit exp_tready();
    return mdl_run && (!mdl_valid || tr) && !(mdl_zq || mdl_pend == MAXP);
  endfunction

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    bit load_ok, force_m, sel, hacc, wrap, tref, tzq;
    if (!rstn) begin
      mdl_run = 0; mdl_valid = 0; mdl_tag = 0; mdl_zq = 0; mdl_ovf = 0; mdl_hacc = 0;
      mdl_cnt = 0; mdl_pend = 0; mdl_zqc = 0; mdl_issued = '0; mdl_data = '0;
      return;
    end
    load_ok  = mdl_run && (!mdl_valid || tr);
    force_m  = mdl_zq || (mdl_pend == MAXP);
    sel      = load_ok && (force_m || (mdl_pend > 0 && !hv));
    hacc     = load_ok && !sel && hv;
    tzq      = sel && mdl_zq;
    tref     = sel && !mdl_zq;
    mdl_hacc = hacc;
    if (sel) begin
      mdl_valid = 1; mdl_data = mdl_zq ? ZQ_W : REF_W; mdl_tag = 1;
    end else if (hacc) begin
      mdl_valid = 1; mdl_data = hd; mdl_tag = 0;
    end else if (tr) begin
      mdl_valid = 0;
    end
    if (tref) mdl_issued = mdl_issued + 16'd1;
    if (!en) begin
      mdl_cnt = 0; mdl_pend = 0; mdl_zqc = 0; mdl_zq = 0;
    end else begin
      wrap    = (mdl_cnt == RI - 1);
      mdl_cnt = wrap ? 0 : mdl_cnt + 1;
      if (wrap && mdl_pend == MAXP) mdl_ovf = 1;
      mdl_pend = mdl_pend + (wrap ? 1 : 0) - (tref ? 1 : 0);
      if (mdl_pend > MAXP) mdl_pend = MAXP;
      if (tzq) mdl_zq = 0;
      if (tref && ZQE != 0) begin
        mdl_zqc++;
        if (mdl_zqc == ZQE) begin
          mdl_zqc = 0; mdl_zq = 1;
        end
      end
    end
    mdl_run = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b1; hv = 1'b0; tr = 1'b1; hd = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    #1;
    total++;
    if (ovalid !== 1'b0 || odata !== 128'h0 || hready !== 1'b0 || status !== 32'h0) begin
      bad++;
      $display("FAIL reset_state valid=%0b data=%h tready=%0b status=%h want all zero",
               ovalid, odata, hready, status);
    end
    rstn = 1'b1;
  endtask

  task automatic test_ref_interval();
    do_reset();
    for (int i = 0; i < 55; i++) begin
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL ref_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      step();
    end
    total++;
    if (status[31:16] !== 16'd5) begin
      bad++;
      $display("FAIL ref_count got=%0d want=5", status[31:16]);
    end
  endtask

  task automatic test_zq_sequence();
    logic [127:0] seq[$];
    int           at[$];
    logic [127:0] want[6];
    want = '{REF_W, REF_W, ZQ_W, REF_W, REF_W, ZQ_W};
    do_reset();
    for (int i = 0; i < 50; i++) begin
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL zq_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      if (ovalid === 1'b1 && (odata === REF_W || odata === ZQ_W)) begin
        seq.push_back(odata);
        at.push_back(i);
      end
      step();
    end
    total++;
    if (seq.size() < 6) begin
      bad++;
      $display("FAIL zq_seq_len got=%0d want>=6", seq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (seq[k] !== want[k]) begin
          bad++;
          $display("FAIL zq_seq[%0d] got=%h want=%h", k, seq[k], want[k]);
        end
      end
      total++;
      if (at[2] != at[1] + 1 || at[5] != at[4] + 1) begin
        bad++;
        $display("FAIL zq_adjacent ref_at=%0d zq_at=%0d want zq right after ref", at[1], at[2]);
      end
    end
  endtask

  task automatic test_host_stream();
    logic [127:0] beats[100];
    logic [127:0] hout[$];
    int           k, nref, guard;
    for (int i = 0; i < 100; i++) beats[i] = {$urandom, $urandom, $urandom, 32'h5A00_0000 | i};
    do_reset();
    hv = 1'b1; k = 0; nref = 0; guard = 0;
    while ((k < 100 || ovalid === 1'b1) && guard < 300) begin
      hv = (k < 100);
      hd = (k < 100) ? beats[k] : '0;
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL stream_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      if (hv) begin
        total++;
        if (hready !== exp_tready()) begin
          bad++;
          $display("FAIL stream_tready cyc=%0d got=%0b want=%0b", cyc, hready, exp_tready());
        end
      end
      if (ovalid === 1'b1) begin
        if (odata === REF_W) nref++;
        else if (odata !== ZQ_W) hout.push_back(odata);
      end
      step();
      if (mdl_hacc) k++;
      guard++;
    end
    total++;
    if (hout.size() != 100 || nref < 1) begin
      bad++;
      $display("FAIL stream_count host=%0d refs=%0d want host=100 refs>=1", hout.size(), nref);
    end else begin
      for (int i = 0; i < 100; i++) begin
        if (hout[i] !== beats[i]) begin
          total++;
          bad++;
          $display("FAIL stream_order idx=%0d got=%h want=%h", i, hout[i], beats[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] word;
    word = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    do_reset();
    hv = 1'b1; hd = word; tr = 1'b0;
    for (int i = 0; i < 110; i++) begin
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL bp_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      if (i >= 2) begin
        total++;
        if (ovalid !== 1'b1 || odata !== word || hready !== 1'b0) begin
          bad++;
          $display("FAIL bp_stable i=%0d valid=%0b data=%h tready=%0b want 1 %h 0",
                   i, ovalid, odata, hready, word);
        end
      end
      step();
    end
    total++;
    if (status[3:0] !== 4'd8 || status[4] !== 1'b1 || status[5] !== 1'b1) begin
      bad++;
      $display("FAIL bp_saturate pend=%0d ovf=%0b urg=%0b want 8 1 1", status[3:0], status[4],
               status[5]);
    end
    tr = 1'b1; hv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL bp_drain cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      step();
    end
    total++;
    if (status[4] !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf_sticky got=%0b want=1", status[4]);
    end
  endtask

  task automatic test_maint_disable();
    int nmaint, nhost;
    do_reset();
    hv = 1'b1;
    for (int i = 0; i < 35; i++) begin
      hd = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL dis_pre cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      step();
    end
    total++;
    if (status[3:0] !== 4'd3) begin
      bad++;
      $display("FAIL dis_pend_before got=%0d want=3", status[3:0]);
    end
    en = 1'b0;
    step();
    #1;
    total++;
    if (status[3:0] !== 4'd0) begin
      bad++;
      $display("FAIL dis_pend_after got=%0d want=0", status[3:0]);
    end
    nmaint = 0; nhost = 0;
    for (int i = 0; i < 30; i++) begin
      hv = ($urandom_range(0, 2) != 0);
      hd = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL dis_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      if (hv) begin
        total++;
        if (hready !== exp_tready()) begin
          bad++;
          $display("FAIL dis_tready cyc=%0d got=%0b want=%0b", cyc, hready, exp_tready());
        end
      end
      if (ovalid === 1'b1) begin
        if (odata === REF_W || odata === ZQ_W) nmaint++;
        else nhost++;
      end
      step();
    end
    total++;
    if (nmaint != 0 || nhost == 0) begin
      bad++;
      $display("FAIL dis_traffic maint=%0d host=%0d want maint=0 host>0", nmaint, nhost);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    hv = 1'b1; tr = 1'b0; hd = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL mid_pre cyc=%0d valid=%0b data=%h want %0b %h",
                 cyc, ovalid, odata, mdl_valid, mdl_data);
      end
      step();
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    total++;
    if (ovalid !== 1'b0 || status !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset valid=%0b status=%h want 0 00000000", ovalid, status);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      hv = ($urandom_range(0, 2) != 0);
      tr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      hd = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++;
      if (ovalid !== mdl_valid || (mdl_valid && odata !== mdl_data) || status !== exp_status()) begin
        bad++;
        $display("FAIL rand_out cyc=%0d valid=%0b data=%h status=%h want %0b %h %h",
                 cyc, ovalid, odata, status, mdl_valid, mdl_data, exp_status());
      end
      if (hv) begin
        total++;
        if (hready !== exp_tready()) begin
          bad++;
          $display("FAIL rand_tready cyc=%0d got=%0b want=%0b", cyc, hready, exp_tready());
        end
      end
      step();
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; hv = 1'b0; tr = 1'b1; hd = '0;
    test_reset();
    test_ref_interval();
    test_zq_sequence();
    test_host_stream();
    test_backpressure();
    test_maint_disable();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
